branch_unit: RTL and testbench
==============================

BRANCH_UNIT -- requirements
Module: branch_unit

Interface
REQ-001 SHALL have the port `clk`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have the port `reset`, input, 1 bit: reset is asynchronous and active-high.
REQ-003 SHALL have the port `status_in`, input, 3 bits: ALU flags {N,V,Z} with [2]=N (negative), [1]=V (overflow), [0]=Z (zero).
REQ-004 SHALL have the port `load_s`, input, 1 bit: when 1, capture `status_in` into the status register.
REQ-005 SHALL have the port `req_valid`, input, 1 bit: a branch request is present.
REQ-006 SHALL have the port `req_ready`, output, 1 bit: the unit accepts a request this cycle.
REQ-007 SHALL have the port `cond`, input, 3 bits: condition code, sampled at the request handshake.
REQ-008 SHALL have the port `imm8`, input, 8 bits: signed two's-complement branch offset, sampled at the request handshake.
REQ-009 SHALL have the port `incr`, input, 1 bit: sequential PC increment request.
REQ-010 SHALL have the port `pc`, output, 9 bits: current program counter.
REQ-011 SHALL have the port `status_q`, output, 3 bits: registered {N,V,Z}.
REQ-012 SHALL have the port `taken`, output, 1 bit: registered branch decision of the last evaluated request.
REQ-013 SHALL have the port `done`, output, 1 bit: one-cycle completion pulse.
REQ-014 SHALL have the port `illegal`, output, 1 bit: asserted together with `done` when `cond` was reserved.

Function
REQ-015 SHALL update `status_q` to `status_in` at every edge with `load_s`=1, in every state; this update is independent of the FSM.
REQ-016 SHALL implement the FSM states IDLE, EVAL, UPDATE and DONE.
REQ-017 SHALL drive `req_ready`=1 only in IDLE, decoded combinationally from the state.
REQ-018 SHALL, on a handshake (`req_valid`&`req_ready`) at edge k, capture `cond` and `imm8` and move IDLE->EVAL.
REQ-019 SHALL, at edge k+1 (EVAL->UPDATE), register `taken` from `status_q` as it stands during the EVAL cycle; a `load_s` at edge k+1 does not affect this decision.
REQ-020 SHALL decode conditions as:
  - 000: always taken
  - 001: taken when Z=1
  - 010: taken when Z=0
  - 011: taken when N!=V
  - 100: taken when (N!=V) or Z=1
  - 101-111: reserved; `taken`=0 and `illegal` is set
REQ-021 SHALL, at edge k+2 (UPDATE->DONE), load `pc` with pc+1+sign_extend(imm8) when `taken`=1, else pc+1.
REQ-022 SHALL compute all PC arithmetic modulo 512 (9-bit wrap), with no error indication on wrap.
REQ-023 SHALL, in DONE, hold `done`=1 (and `illegal`=1 if the condition was reserved) for exactly one cycle, then DONE->IDLE at edge k+3.
REQ-024 SHALL hold `taken` until the next EVAL->UPDATE transition.
REQ-025 SHALL, in IDLE with `incr`=1 and no handshake, set `pc` to pc+1 (mod 512).
REQ-026 SHALL, when `incr` and a handshake coincide, give the request priority and discard `incr`.
REQ-027 SHALL ignore `incr` outside IDLE.
REQ-028 SHALL ignore `req_valid` outside IDLE; the request must be held until accepted.
REQ-029 SHALL allow back-to-back requests: the earliest next handshake is the edge after DONE (edge k+4), giving a minimum of 4 cycles per request.
REQ-030 SHALL treat `imm8`=8'h80 as -128 and `imm8`=8'h7F as +127.

Reset
REQ-031 SHALL, while `reset`=1, immediately (not waiting for a clock edge) force state=IDLE, `pc`=0, `status_q`=000, `taken`=0, `done`=0, `illegal`=0.
REQ-032 SHALL drive `req_ready`=1 from the first cycle after `reset` deasserts.
REQ-033 SHALL abandon any in-flight request when `reset` asserts mid-operation: `pc` is not updated and no `done` is produced.
REQ-034 SHALL ignore `load_s` and `incr` while `reset`=1.

Verification
REQ-035 SHALL be verified for BEQ taken: `load_s` with status_in=001, then request cond=001, imm8=8'h05 at pc=10 -> `taken`=1, `pc`=16, `done` pulses once at handshake+3 cycles.
REQ-036 SHALL be verified for BLT with N=1, V=1 and a negative offset: status 110, cond=011, imm8=8'hFE at pc=10 -> `taken`=0, `pc`=11.
REQ-037 SHALL be verified for wrap-around: pc=511 with `incr`=1 -> `pc`=0; and pc=0 with cond=000, imm8=8'h80 -> `pc`=385.
REQ-038 SHALL be verified for simultaneous events: `incr`=1 and handshake cond=000, imm8=1 at pc=20 -> `pc`=22, never 21; a `load_s` changing Z during EVAL does not alter `taken`.
REQ-039 SHALL be verified for a reserved code: cond=110 -> `taken`=0, `pc`+1, `done`=1 and `illegal`=1 in the same single cycle.
REQ-040 SHALL be verified for reset mid-operation: `reset` asserted during UPDATE -> `pc`=0 and `status_q`=000 without a clock edge, no `done`, and `req_ready`=1 after release.

Source files
------------

// File: rtl/branch_unit.sv
// -----------------------------------------------------------------------------
// branch_unit
//   Holds a {N,V,Z} status register and a 9-bit program counter. The PC either
//   steps sequentially or applies a conditional, signed 8-bit relative branch.
//   Each branch request walks a four-state FSM: IDLE -> EVAL -> UPDATE -> DONE.
//
// Ports
//   clk        in   clock; all state changes on the rising edge
//   reset      in   asynchronous, active-high reset
//   status_in  in   [2:0] ALU flags {N,V,Z}
//   load_s     in   capture status_in into status_q
//   req_valid  in   branch request present
//   req_ready  out  request accepted this cycle (high only in IDLE)
//   cond       in   [2:0] condition code, sampled at the handshake
//   imm8       in   [7:0] signed branch offset, sampled at the handshake
//   incr       in   sequential PC increment (honoured only in IDLE)
//   pc         out  [8:0] program counter
//   status_q   out  [2:0] registered {N,V,Z}
//   taken      out  branch decision of the last evaluated request
//   done       out  one-cycle completion pulse
//   illegal    out  high together with done when cond was reserved
// -----------------------------------------------------------------------------
module branch_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] status_in,
    input  logic       load_s,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [2:0] cond,
    input  logic [7:0] imm8,
    input  logic       incr,
    output logic [8:0] pc,
    output logic [2:0] status_q,
    output logic       taken,
    output logic       done,
    output logic       illegal
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EVAL   = 2'd1,
        UPDATE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t     state;
    logic [2:0] cond_r;
    logic [7:0] imm_r;
    logic       cond_met;
    logic       cond_reserved;
    logic [8:0] pc_next_seq;
    logic [8:0] pc_next_branch;

    assign req_ready = (state == IDLE);

    // Condition decode against the registered flags.
    // NOTE: every signal assigned in always_comb receives a default first, so
    // no path can leave it unassigned and infer a latch.
    always_comb begin
        cond_met      = 1'b0;
        cond_reserved = 1'b0;
        case (cond_r)
            3'b000:  cond_met = 1'b1;
            3'b001:  cond_met = status_q[0];
            3'b010:  cond_met = ~status_q[0];
            3'b011:  cond_met = status_q[2] ^ status_q[1];
            3'b100:  cond_met = (status_q[2] ^ status_q[1]) | status_q[0];
            default: cond_reserved = 1'b1;
        endcase
    end

    // 9-bit adders wrap modulo 512 by construction.
    assign pc_next_seq    = pc + 9'd1;
    assign pc_next_branch = pc + 9'd1 + {imm_r[7], imm_r};

    // Status register updates in every state, independent of the FSM.
    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples its inputs as they stood before the clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            status_q <= 3'b000;
        end else if (load_s) begin
            status_q <= status_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            pc      <= 9'd0;
            taken   <= 1'b0;
            done    <= 1'b0;
            illegal <= 1'b0;
            cond_r  <= 3'b000;
            imm_r   <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    done    <= 1'b0;
                    illegal <= 1'b0;
                    // A handshake wins over a simultaneous incr.
                    if (req_valid) begin
                        cond_r <= cond;
                        imm_r  <= imm8;
                        state  <= EVAL;
                    end else if (incr) begin
                        pc <= pc_next_seq;
                    end
                end
                EVAL: begin
                    // Decision uses status_q as held during this cycle; a
                    // load_s on the same edge lands only afterwards.
                    taken <= cond_met;
                    state <= UPDATE;
                end
                UPDATE: begin
                    pc      <= taken ? pc_next_branch : pc_next_seq;
                    done    <= 1'b1;
                    illegal <= cond_reserved;
                    state   <= DONE;
                end
                DONE: begin
                    done    <= 1'b0;
                    illegal <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_branch_unit.sv
// -----------------------------------------------------------------------------
// tb_branch_unit
//   Directed self-checking bench for branch_unit. Expected values are computed
//   by hand from the condition table and the 9-bit wrapping PC arithmetic.
// -----------------------------------------------------------------------------
module tb_branch_unit;

    logic       clk;
    logic       reset;
    logic [2:0] status_in;
    logic       load_s;
    logic       req_valid;
    logic       req_ready;
    logic [2:0] cond;
    logic [7:0] imm8;
    logic       incr;
    logic [8:0] pc;
    logic [2:0] status_q;
    logic       taken;
    logic       done;
    logic       illegal;

    int tests = 0;
    int fails = 0;

    branch_unit dut (
        .clk       (clk),
        .reset     (reset),
        .status_in (status_in),
        .load_s    (load_s),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .cond      (cond),
        .imm8      (imm8),
        .incr      (incr),
        .pc        (pc),
        .status_q  (status_q),
        .taken     (taken),
        .done      (done),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic incr_n(input int n);
        incr = 1'b1;
        repeat (n) tick();
        incr = 1'b0;
    endtask

    task automatic load_status(input logic [2:0] s);
        load_s    = 1'b1;
        status_in = s;
        tick();
        load_s    = 1'b0;
        check("status_load", {6'd0, status_q}, {6'd0, s});
    endtask

    // One complete request: handshake at edge k, then EVAL, UPDATE, DONE.
    task automatic run_req(input string tag, input logic [2:0] c, input logic [7:0] im,
                           input logic hold_incr, input logic load_in_eval,
                           input logic [2:0] eval_status, input logic exp_taken,
                           input logic [8:0] pc0, input logic [8:0] exp_pc,
                           input logic exp_ill);
        check({tag, "_ready"}, {8'd0, req_ready}, 9'd1);
        req_valid = 1'b1;
        cond      = c;
        imm8      = im;
        incr      = hold_incr;
        tick();                                   // edge k
        req_valid = 1'b0;
        cond      = ~c;                           // must already be captured
        imm8      = ~im;
        if (load_in_eval) begin
            load_s    = 1'b1;
            status_in = eval_status;
        end
        check({tag, "_eval_pc"}, pc, pc0);
        check({tag, "_eval_busy"}, {8'd0, req_ready}, 9'd0);
        check({tag, "_eval_done"}, {8'd0, done}, 9'd0);
        tick();                                   // edge k+1
        load_s = 1'b0;
        check({tag, "_taken"}, {8'd0, taken}, {8'd0, exp_taken});
        check({tag, "_upd_pc"}, pc, pc0);
        check({tag, "_upd_done"}, {8'd0, done}, 9'd0);
        tick();                                   // edge k+2
        check({tag, "_pc"}, pc, exp_pc);
        check({tag, "_done"}, {8'd0, done}, 9'd1);
        check({tag, "_illegal"}, {8'd0, illegal}, {8'd0, exp_ill});
        incr = 1'b0;
        tick();                                   // edge k+3
        check({tag, "_done_clr"}, {8'd0, done}, 9'd0);
        check({tag, "_ill_clr"}, {8'd0, illegal}, 9'd0);
        check({tag, "_ready_again"}, {8'd0, req_ready}, 9'd1);
        check({tag, "_pc_hold"}, pc, exp_pc);
    endtask

    initial begin
        reset     = 1'b0;
        status_in = 3'b000;
        load_s    = 1'b0;
        req_valid = 1'b0;
        cond      = 3'b000;
        imm8      = 8'h00;
        incr      = 1'b0;

        // Asynchronous reset, observed before any clock edge.
        #2 reset = 1'b1;
        #1;
        check("rst_pc", pc, 9'd0);
        check("rst_status", {6'd0, status_q}, 9'd0);
        check("rst_taken", {8'd0, taken}, 9'd0);
        check("rst_done", {8'd0, done}, 9'd0);
        check("rst_illegal", {8'd0, illegal}, 9'd0);
        check("rst_ready", {8'd0, req_ready}, 9'd1);
        tick();
        reset = 1'b0;
        tick();
        check("post_rst_ready", {8'd0, req_ready}, 9'd1);

        // BEQ taken: Z=1, +5 from pc 10 -> 16.
        incr_n(10);
        check("incr_to_10", pc, 9'd10);
        load_status(3'b001);
        run_req("beq", 3'b001, 8'h05, 1'b0, 1'b0, 3'b000, 1'b1, 9'd10, 9'd16, 1'b0);

        // BLT with N=V: not taken, negative offset ignored -> 11.
        do_reset();
        incr_n(10);
        load_status(3'b110);
        run_req("blt_nt", 3'b011, 8'hFE, 1'b0, 1'b0, 3'b000, 1'b0, 9'd10, 9'd11, 1'b0);
        // BLT with N!=V: taken, 11 + 1 - 2 = 10.
        load_status(3'b100);
        run_req("blt_t", 3'b011, 8'hFE, 1'b0, 1'b0, 3'b000, 1'b1, 9'd11, 9'd10, 1'b0);
        // BNE with Z=0 (N=1,V=0 still loaded): 10 + 1 + 3 = 14.
        run_req("bne", 3'b010, 8'h03, 1'b0, 1'b0, 3'b000, 1'b1, 9'd10, 9'd14, 1'b0);

        // Wrap-around: 511 + 1 -> 0, then 0 + 1 - 128 -> 385, then 385 + 128 -> 1.
        do_reset();
        incr_n(511);
        check("pc_511", pc, 9'd511);
        incr_n(1);
        check("pc_wrap_0", pc, 9'd0);
        run_req("neg128", 3'b000, 8'h80, 1'b0, 1'b0, 3'b000, 1'b1, 9'd0, 9'd385, 1'b0);
        run_req("pos127", 3'b000, 8'h7F, 1'b0, 1'b0, 3'b000, 1'b1, 9'd385, 9'd1, 1'b0);

        // incr colliding with a handshake and held through the request: 20 -> 22.
        do_reset();
        incr_n(20);
        run_req("incr_coll", 3'b000, 8'h01, 1'b1, 1'b0, 3'b000, 1'b1, 9'd20, 9'd22, 1'b0);

        // load_s clearing Z during EVAL must not flip a BEQ decision: 22 + 4 = 26.
        load_status(3'b001);
        run_req("z_in_eval", 3'b001, 8'h03, 1'b0, 1'b1, 3'b000, 1'b1, 9'd22, 9'd26, 1'b0);
        check("z_in_eval_status", {6'd0, status_q}, 9'd0);

        // Reserved condition: not taken, pc + 1, illegal with done.
        run_req("reserved", 3'b110, 8'h10, 1'b0, 1'b0, 3'b000, 1'b0, 9'd26, 9'd27, 1'b1);

        // BLE via Z alone: 27 + 1 + 2 = 30.
        load_status(3'b001);
        run_req("ble", 3'b100, 8'h02, 1'b0, 1'b0, 3'b000, 1'b1, 9'd27, 9'd30, 1'b0);

        // Reset during UPDATE abandons the request.
        load_status(3'b111);
        req_valid = 1'b1;
        cond      = 3'b000;
        imm8      = 8'h10;
        tick();                                   // handshake, -> EVAL
        req_valid = 1'b0;
        tick();                                   // -> UPDATE
        #1 reset = 1'b1;
        #1;
        check("mid_rst_pc", pc, 9'd0);
        check("mid_rst_status", {6'd0, status_q}, 9'd0);
        check("mid_rst_done", {8'd0, done}, 9'd0);
        check("mid_rst_taken", {8'd0, taken}, 9'd0);
        check("mid_rst_ready", {8'd0, req_ready}, 9'd1);
        load_s    = 1'b1;
        status_in = 3'b111;
        incr      = 1'b1;
        tick();                                   // edge while reset held
        check("rst_ign_status", {6'd0, status_q}, 9'd0);
        check("rst_ign_pc", pc, 9'd0);
        reset  = 1'b0;
        load_s = 1'b0;
        incr   = 1'b0;
        tick();
        check("rel_ready", {8'd0, req_ready}, 9'd1);
        check("rel_no_done", {8'd0, done}, 9'd0);
        check("rel_pc", pc, 9'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
